mac_bus_master: RTL and testbench
=================================

Name: mac_bus_master

Overview:
- Initiator end of the Mac-side 68000 bus: runs the slow 8 MHz bus cycle on behalf of the fast CPU when it accesses I/O space.
- Drives nASMac, nUDSMac, nLDSMac, RnWMac, nVMAMac and the data-output enable.
- Samples nDTACKMac, nVPAMac and nBERRMac, and returns a level Ready/Err to the fast-bus responder.
- Runs entirely on FCLK; Mac clock timing arrives as pre-synchronised single-FCLK edge pulses.

Parameters:
TIMEOUT, 255, C8M falling edges in WAIT before the cycle is forced to terminate with Err (8-bit counter).

Ports:
FCLK  in  1  fast clock; all state changes on its rising edge
nRES  in  1  synchronous active-low reset
C8MRise  in  1  one-FCLK pulse per Mac 8 MHz rising edge; never coincident with C8MFall
C8MFall  in  1  one-FCLK pulse per Mac 8 MHz falling edge
EStart  in  1  one-FCLK pulse at the start of an E-clock high phase
EEnd  in  1  one-FCLK pulse at the E-clock falling edge
Req  in  1  fast-side I/O cycle request; level, held until Ack or Err seen
RnW  in  1  fast-side direction (1 = read)
UDS  in  1  fast-side upper strobe active (1 = active)
LDS  in  1  fast-side lower strobe active (1 = active)
nDTACKMac  in  1  Mac DTACK
nVPAMac  in  1  Mac VPA
nBERRMac  in  1  Mac BERR
nASMac  out  1  Mac address strobe
nUDSMac  out  1  Mac upper data strobe
nLDSMac  out  1  Mac lower data strobe
RnWMac  out  1  Mac read/write
nVMAMac  out  1  Mac valid memory address, VPA cycles only
nDoutOE  out  1  fast-to-Mac data driver enable (write cycles)
DLatch  out  1  one-FCLK pulse to capture read data
Ack  out  1  cycle complete, normal; level
Err  out  1  cycle complete, bus error or timeout; level

Behaviour:
- Reset (nRES low at FCLK rise) has priority over everything, including mid-cycle. Result: state IDLE; nASMac, nUDSMac, nLDSMac, nVMAMac, nDoutOE = 1; RnWMac = 1; DLatch, Ack, Err = 0; timeout counter = 0.
- Latched per cycle, on IDLE->ADDR: RnW, UDS, LDS. Fast-side changes mid-cycle are ignored.
- IDLE: Req=1 and C8MRise -> ADDR. Drive RnWMac = latched RnW. nDoutOE = 0 if write.
- ADDR: C8MFall -> ASRT. nASMac = 0. If read, nUDSMac/nLDSMac = ~UDS/~LDS.
- ASRT: next C8MFall -> WAIT. If write, assert the data strobes now (one full C8M period after nAS). Clear counter.
- WAIT: evaluate on each C8MFall, priority order:
  - nBERRMac=0 -> TERM, Err.
  - nDTACKMac=0 -> TERM, Ack; DLatch pulse if read.
  - nVPAMac=0 -> VPAW.
  - counter==TIMEOUT -> TERM, Err.
  - otherwise counter+1 (8-bit, saturates at TIMEOUT).
  - With no edge pulse, hold.
- VPAW:
  - nBERRMac=0 on C8MFall -> TERM, Err at any time.
  - First EStart -> nVMAMac = 0.
  - EEnd with nVMAMac=0 -> TERM, Ack; DLatch pulse if read.
  - An EEnd before EStart is ignored.
- TERM:
  - Ack/Err is set on TERM entry (same FCLK edge as the DLatch pulse).
  - Next C8MRise: nASMac, data strobes, nVMAMac = 1 -> REC.
- REC:
  - nDoutOE = 1; RnWMac = 1.
  - Ack/Err held until Req=0; Ack/Err cleared when Req is seen low.
  - Return to IDLE on the first C8MRise with Req=0. A new cycle needs a further C8MRise (no back-to-back cycle in the same edge).
- Ack and Err are never both 1. Errors: DTACK and BERR low together -> Err wins.
- A Req drop before termination is illegal; the block completes the Mac cycle regardless.

Test Plan:
- Read with DTACK low at the second WAIT C8MFall:
  - nASMac low on the first C8MFall after start.
  - DS with AS.
  - DLatch pulse and Ack on the DTACK-sample edge.
  - Strobes high on the next C8MRise.
  - Ack drops after Req=0.
- Word write, UDS=LDS=1:
  - nDoutOE low and RnWMac=0 from the ADDR entry.
  - Data strobes low exactly one C8M period after nASMac.
  - No DLatch.
  - nDoutOE high in REC.
- VPA read:
  - nVPAMac low in WAIT, with EEnd pulsed before EStart.
  - nVMAMac low only after EStart.
  - Ack on the following EEnd.
- Bus error: nBERRMac and nDTACKMac low on the same C8MFall -> Err=1, Ack=0, no DLatch.
- Timeout, TIMEOUT=4, no responder -> Err on the fifth WAIT C8MFall and strobes released.
- nRES low while in WAIT with strobes asserted -> all outputs at reset values after one FCLK. A new Req afterwards starts cleanly from IDLE.

Source files
------------

// File: rtl/mac_bus_master.sv
// Purpose: initiator for the Mac-side 68000 bus; runs one slow I/O cycle per fast-side Req.
// Latency: nAS falls on the first C8M falling edge after start; termination follows DTACK/VPA/BERR/timeout.
// Backpressure: Req is a held level; Ack/Err stay up until Req is seen low, then the block re-arms.
module mac_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic FCLK,
  input  logic nRES,
  input  logic C8MRise,
  input  logic C8MFall,
  input  logic EStart,
  input  logic EEnd,
  input  logic Req,
  input  logic RnW,
  input  logic UDS,
  input  logic LDS,
  input  logic nDTACKMac,
  input  logic nVPAMac,
  input  logic nBERRMac,
  output logic nASMac,
  output logic nUDSMac,
  output logic nLDSMac,
  output logic RnWMac,
  output logic nVMAMac,
  output logic nDoutOE,
  output logic DLatch,
  output logic Ack,
  output logic Err
);

  // Bus cycle phases
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_ASRT = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_VPAW = 3'd4;
  localparam logic [2:0] ST_TERM = 3'd5;
  localparam logic [2:0] ST_REC  = 3'd6;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  logic [2:0] r_state;
  logic [2:0] w_next_state;

  // Per-cycle copy of the fast-side request attributes
  logic       r_rnw;
  logic       r_uds;
  logic       r_lds;

  logic [7:0] r_cnt;

  logic       r_nas;
  logic       r_nuds;
  logic       r_nlds;
  logic       r_rnwmac;
  logic       r_nvma;
  logic       r_ndoutoe;
  logic       r_dlatch;
  logic       r_ack;
  logic       r_err;

  // Transition events, one per decision point
  logic w_idle_go;
  logic w_addr_go;
  logic w_asrt_go;
  logic w_wait_berr;
  logic w_wait_dtack;
  logic w_wait_vpa;
  logic w_wait_tmo;
  logic w_wait_inc;
  logic w_vpaw_berr;
  logic w_vpaw_estart;
  logic w_vpaw_done;
  logic w_term_ok;
  logic w_term_err;
  logic w_term_go;
  logic w_rec_clr;
  logic w_rec_go;

  // Decode edge pulses against the current phase; WAIT checks BERR, DTACK, VPA, timeout in that order
  always_comb begin
    w_idle_go     = (r_state == ST_IDLE) && Req && C8MRise;
    w_addr_go     = (r_state == ST_ADDR) && C8MFall;
    w_asrt_go     = (r_state == ST_ASRT) && C8MFall;
    w_wait_berr   = (r_state == ST_WAIT) && C8MFall && !nBERRMac;
    w_wait_dtack  = (r_state == ST_WAIT) && C8MFall && nBERRMac && !nDTACKMac;
    w_wait_vpa    = (r_state == ST_WAIT) && C8MFall && nBERRMac && nDTACKMac && !nVPAMac;
    w_wait_tmo    = (r_state == ST_WAIT) && C8MFall && nBERRMac && nDTACKMac && nVPAMac
                    && (r_cnt == LP_TIMEOUT);
    w_wait_inc    = (r_state == ST_WAIT) && C8MFall && nBERRMac && nDTACKMac && nVPAMac
                    && (r_cnt != LP_TIMEOUT);
    w_vpaw_berr   = (r_state == ST_VPAW) && C8MFall && !nBERRMac;
    // EEnd only counts once VMA has been asserted by an EStart in this cycle
    w_vpaw_estart = (r_state == ST_VPAW) && !w_vpaw_berr && EStart && r_nvma;
    w_vpaw_done   = (r_state == ST_VPAW) && !w_vpaw_berr && EEnd && !r_nvma;
    w_term_ok     = w_wait_dtack || w_vpaw_done;
    w_term_err    = w_wait_berr || w_wait_tmo || w_vpaw_berr;
    w_term_go     = (r_state == ST_TERM) && C8MRise;
    w_rec_clr     = (r_state == ST_REC) && !Req;
    w_rec_go      = w_rec_clr && C8MRise;
  end

  // Next-phase selection
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_idle_go) w_next_state = ST_ADDR;
      ST_ADDR: if (w_addr_go) w_next_state = ST_ASRT;
      ST_ASRT: if (w_asrt_go) w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (w_term_ok || w_term_err) w_next_state = ST_TERM;
        else if (w_wait_vpa)         w_next_state = ST_VPAW;
      end
      ST_VPAW: if (w_term_ok || w_term_err) w_next_state = ST_TERM;
      ST_TERM: if (w_term_go) w_next_state = ST_REC;
      ST_REC:  if (w_rec_go)  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Phase register
  always_ff @(posedge FCLK) begin
    if (!nRES) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Capture direction and strobes at cycle start; later fast-side changes are ignored
  always_ff @(posedge FCLK) begin
    if (!nRES) begin
      r_rnw <= 1'b1;
      r_uds <= 1'b0;
      r_lds <= 1'b0;
    end else if (w_idle_go) begin
      r_rnw <= RnW;
      r_uds <= UDS;
      r_lds <= LDS;
    end
  end

  // Timeout counter: C8M falls spent in WAIT, saturating at the limit
  always_ff @(posedge FCLK) begin
    if (!nRES) begin
      r_cnt <= 8'd0;
    end else if (w_asrt_go) begin
      r_cnt <= 8'd0;
    end else if (w_wait_inc) begin
      r_cnt <= (r_cnt < LP_TIMEOUT) ? r_cnt + 8'd1 : LP_TIMEOUT;
    end
  end

  // Direction and data driver enable: set at cycle start, released on entering recovery
  always_ff @(posedge FCLK) begin
    if (!nRES) begin
      r_rnwmac  <= 1'b1;
      r_ndoutoe <= 1'b1;
    end else if (w_idle_go) begin
      r_rnwmac  <= RnW;
      r_ndoutoe <= RnW;
    end else if (w_term_go) begin
      r_rnwmac  <= 1'b1;
      r_ndoutoe <= 1'b1;
    end
  end

  // Address strobe: low from the first C8M fall until the C8M rise after termination
  always_ff @(posedge FCLK) begin
    if (!nRES)          r_nas <= 1'b1;
    else if (w_addr_go) r_nas <= 1'b0;
    else if (w_term_go) r_nas <= 1'b1;
  end

  // Data strobes: with AS for reads, one C8M period later for writes so write data is settled
  always_ff @(posedge FCLK) begin
    if (!nRES) begin
      r_nuds <= 1'b1;
      r_nlds <= 1'b1;
    end else if ((w_addr_go && r_rnw) || (w_asrt_go && !r_rnw)) begin
      r_nuds <= ~r_uds;
      r_nlds <= ~r_lds;
    end else if (w_term_go) begin
      r_nuds <= 1'b1;
      r_nlds <= 1'b1;
    end
  end

  // VMA for 6800-style peripheral cycles, asserted at the first E high phase after VPA
  always_ff @(posedge FCLK) begin
    if (!nRES)              r_nvma <= 1'b1;
    else if (w_vpaw_estart) r_nvma <= 1'b0;
    else if (w_term_go)     r_nvma <= 1'b1;
  end

  // Read data capture strobe, one FCLK wide on successful read termination
  always_ff @(posedge FCLK) begin
    if (!nRES) r_dlatch <= 1'b0;
    else       r_dlatch <= w_term_ok && r_rnw;
  end

  // Completion status: set on entering TERM, dropped once the requester releases Req in recovery
  always_ff @(posedge FCLK) begin
    if (!nRES) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else if (w_term_ok) begin
      r_ack <= 1'b1;
      r_err <= 1'b0;
    end else if (w_term_err) begin
      r_ack <= 1'b0;
      r_err <= 1'b1;
    end else if (w_rec_clr) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end
  end

  assign nASMac  = r_nas;
  assign nUDSMac = r_nuds;
  assign nLDSMac = r_nlds;
  assign RnWMac  = r_rnwmac;
  assign nVMAMac = r_nvma;
  assign nDoutOE = r_ndoutoe;
  assign DLatch  = r_dlatch;
  assign Ack     = r_ack;
  assign Err     = r_err;

endmodule

// File: tb/tb_mac_bus_master.sv
// Directed bench for mac_bus_master: read, word write, VPA read, bus error, timeout, mid-cycle reset.
// Output vector order: {nAS, nUDS, nLDS, RnWMac, nVMA, nDoutOE, DLatch, Ack, Err}.
// Inputs change 1 time unit after a rising FCLK edge; outputs are sampled at the same point.
module tb_mac_bus_master;

  localparam int P_RISE   = 0;
  localparam int P_FALL   = 1;
  localparam int P_ESTART = 2;
  localparam int P_EEND   = 3;

  logic FCLK = 1'b0;
  logic nRES, C8MRise, C8MFall, EStart, EEnd;
  logic Req, RnW, UDS, LDS, nDTACKMac, nVPAMac, nBERRMac;
  logic nASMac, nUDSMac, nLDSMac, RnWMac, nVMAMac, nDoutOE, DLatch, Ack, Err;

  int n_cmp = 0;
  int n_err = 0;

  mac_bus_master #(.TIMEOUT(4)) dut (
    .FCLK(FCLK), .nRES(nRES), .C8MRise(C8MRise), .C8MFall(C8MFall),
    .EStart(EStart), .EEnd(EEnd), .Req(Req), .RnW(RnW), .UDS(UDS), .LDS(LDS),
    .nDTACKMac(nDTACKMac), .nVPAMac(nVPAMac), .nBERRMac(nBERRMac),
    .nASMac(nASMac), .nUDSMac(nUDSMac), .nLDSMac(nLDSMac), .RnWMac(RnWMac),
    .nVMAMac(nVMAMac), .nDoutOE(nDoutOE), .DLatch(DLatch), .Ack(Ack), .Err(Err)
  );

  always #5 FCLK = ~FCLK;

  function automatic logic [8:0] outs();
    return {nASMac, nUDSMac, nLDSMac, RnWMac, nVMAMac, nDoutOE, DLatch, Ack, Err};
  endfunction

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = outs();
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One-FCLK pulse on the selected timing input, returning 1 unit after the edge that consumed it
  task automatic pulse(input int sel);
    case (sel)
      P_RISE:   C8MRise = 1'b1;
      P_FALL:   C8MFall = 1'b1;
      P_ESTART: EStart  = 1'b1;
      default:  EEnd    = 1'b1;
    endcase
    @(posedge FCLK); #1;
    C8MRise = 1'b0; C8MFall = 1'b0; EStart = 1'b0; EEnd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge FCLK); #1;
    end
  endtask

  initial begin
    nRES = 1'b0; C8MRise = 1'b0; C8MFall = 1'b0; EStart = 1'b0; EEnd = 1'b0;
    Req = 1'b0; RnW = 1'b1; UDS = 1'b0; LDS = 1'b0;
    nDTACKMac = 1'b1; nVPAMac = 1'b1; nBERRMac = 1'b1;
    idle(2);
    chk("reset", 9'b111111000);
    nRES = 1'b1;

    // Byte read (upper), DTACK on the second WAIT fall
    Req = 1'b1; RnW = 1'b1; UDS = 1'b1; LDS = 1'b0;
    pulse(P_FALL);
    chk("rd_fall_in_idle", 9'b111111000);
    pulse(P_RISE);
    chk("rd_addr", 9'b111111000);
    RnW = 1'b0; UDS = 1'b0; LDS = 1'b1;
    pulse(P_FALL);
    chk("rd_as_ds", 9'b001111000);
    pulse(P_FALL);
    chk("rd_wait", 9'b001111000);
    pulse(P_FALL);
    chk("rd_wait_fall1", 9'b001111000);
    nDTACKMac = 1'b0;
    pulse(P_FALL);
    chk("rd_dtack_ack_dlatch", 9'b001111110);
    idle(1);
    chk("rd_dlatch_1clk", 9'b001111010);
    nDTACKMac = 1'b1;
    pulse(P_RISE);
    chk("rd_rec_strobes_up", 9'b111111010);
    Req = 1'b0;
    idle(1);
    chk("rd_ack_drop", 9'b111111000);
    pulse(P_RISE);

    // Word write
    Req = 1'b1; RnW = 1'b0; UDS = 1'b1; LDS = 1'b1;
    pulse(P_RISE);
    chk("wr_addr_oe", 9'b111010000);
    pulse(P_FALL);
    chk("wr_as_only", 9'b011010000);
    pulse(P_FALL);
    chk("wr_ds_late", 9'b000010000);
    nDTACKMac = 1'b0;
    pulse(P_FALL);
    chk("wr_ack_nolatch", 9'b000010010);
    nDTACKMac = 1'b1;
    pulse(P_RISE);
    chk("wr_rec_oe_off", 9'b111111010);
    Req = 1'b0;
    idle(1);
    chk("wr_ack_drop", 9'b111111000);
    pulse(P_RISE);

    // VPA read (lower byte), EEnd before EStart ignored
    Req = 1'b1; RnW = 1'b1; UDS = 1'b0; LDS = 1'b1;
    pulse(P_RISE);
    pulse(P_FALL);
    chk("vpa_as_lds", 9'b010111000);
    pulse(P_FALL);
    nVPAMac = 1'b0;
    pulse(P_FALL);
    chk("vpa_enter", 9'b010111000);
    pulse(P_EEND);
    chk("vpa_early_eend", 9'b010111000);
    pulse(P_ESTART);
    chk("vpa_vma", 9'b010101000);
    idle(2);
    chk("vpa_hold", 9'b010101000);
    pulse(P_EEND);
    chk("vpa_ack", 9'b010101110);
    nVPAMac = 1'b1;
    pulse(P_RISE);
    chk("vpa_rec", 9'b111111010);
    Req = 1'b0;
    idle(1);
    chk("vpa_ack_drop", 9'b111111000);
    pulse(P_RISE);

    // Bus error together with DTACK: error wins
    Req = 1'b1; RnW = 1'b1; UDS = 1'b1; LDS = 1'b1;
    pulse(P_RISE);
    pulse(P_FALL);
    chk("be_as_ds", 9'b000111000);
    pulse(P_FALL);
    nBERRMac = 1'b0; nDTACKMac = 1'b0;
    pulse(P_FALL);
    chk("be_err", 9'b000111001);
    nBERRMac = 1'b1; nDTACKMac = 1'b1;
    pulse(P_RISE);
    chk("be_rec", 9'b111111001);
    Req = 1'b0;
    idle(1);
    chk("be_err_drop", 9'b111111000);
    pulse(P_RISE);

    // Timeout with limit 4: Err on the fifth WAIT fall
    Req = 1'b1; RnW = 1'b1; UDS = 1'b1; LDS = 1'b0;
    pulse(P_RISE);
    pulse(P_FALL);
    pulse(P_FALL);
    chk("to_wait", 9'b001111000);
    for (int i = 0; i < 4; i++) pulse(P_FALL);
    chk("to_fall4_pending", 9'b001111000);
    pulse(P_FALL);
    chk("to_fall5_err", 9'b001111001);
    pulse(P_RISE);
    chk("to_released", 9'b111111001);
    Req = 1'b0;
    idle(1);
    chk("to_err_drop", 9'b111111000);
    pulse(P_RISE);

    // Reset in WAIT with strobes down, then a clean new read
    Req = 1'b1; RnW = 1'b0; UDS = 1'b1; LDS = 1'b1;
    pulse(P_RISE);
    pulse(P_FALL);
    pulse(P_FALL);
    chk("rst_pre", 9'b000010000);
    nRES = 1'b0;
    idle(1);
    chk("rst_mid", 9'b111111000);
    nRES = 1'b1;
    RnW = 1'b1;
    pulse(P_RISE);
    pulse(P_FALL);
    chk("rst_new_as", 9'b000111000);
    pulse(P_FALL);
    nDTACKMac = 1'b0;
    pulse(P_FALL);
    chk("rst_new_ack", 9'b000111110);
    nDTACKMac = 1'b1;
    pulse(P_RISE);
    Req = 1'b0;
    idle(1);
    chk("rst_new_done", 9'b111111000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
